// File: rtl/spigot_pkg.sv
// Shared definitions for the spigot e engine.
//   cw()        : clog2-based width helper, never returns less than 1
//   state_e     : engine FSM states
//   INT_DIGIT_E : integer part of e, emitted before the fractional digits
package spigot_pkg;

  localparam int INT_DIGIT_E = 2;

  function automatic int cw(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    EMIT_INT,
    LOAD,
    DIV,
    WRITE,
    OUT,
    DONE
  } state_e;

endpackage

// File: rtl/spigot_divu.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Ports:
//   clk, rst   : clock, async active-high reset
//   go         : start a division; the first quotient bit is resolved in
//                the go cycle itself, straight from dividend/divisor
//   dividend   : XW-bit dividend
//   divisor    : AW-bit divisor
//   quot       : QW-bit quotient (caller guarantees quotient < 2^QW)
//   rem        : AW-bit remainder (always < divisor)
//   ready      : high once all QW quotient bits have been resolved,
//                i.e. QW cycles after go
module spigot_divu
  import spigot_pkg::*;
#(
  parameter int XW = 9,
  parameter int AW = 6,
  parameter int QW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [XW-1:0] dividend,
  input  logic [AW-1:0] divisor,
  output logic [QW-1:0] quot,
  output logic [AW-1:0] rem,
  output logic          ready
);

  // The divisor shifted by up to QW-1 bits must fit alongside the dividend.
  localparam int CW  = AW + QW;
  localparam int CNW = cw(QW + 1);

  logic [XW-1:0]  rem_q, rem_d, src_rem;
  logic [QW-1:0]  quot_q, quot_d, src_quot;
  logic [AW-1:0]  dvs_q, dvs_d, src_dvs;
  logic [CNW-1:0] cnt_q, cnt_d, step_bit;
  logic [CW-1:0]  shifted;

  always_comb begin
    // On go the step works on the fresh operands rather than the registers.
    src_rem  = go ? dividend : rem_q;
    src_quot = go ? '0 : quot_q;
    src_dvs  = go ? divisor : dvs_q;
    step_bit = go ? CNW'(QW - 1) : CNW'(QW - 1) - cnt_q;
    shifted  = CW'(src_dvs) << step_bit;

    rem_d  = src_rem;
    quot_d = src_quot;
    dvs_d  = src_dvs;
    cnt_d  = cnt_q;
    if (go || cnt_q != CNW'(QW)) begin
      if (CW'(src_rem) >= shifted) begin
        rem_d  = XW'(CW'(src_rem) - shifted);
        quot_d = src_quot | (QW'(1) << step_bit);
      end
      cnt_d = go ? CNW'(1) : cnt_q + CNW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= CNW'(QW);
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quot  = quot_q;
  assign rem   = rem_q[AW-1:0];
  assign ready = (cnt_q == CNW'(QW));

endmodule

// File: rtl/spigot_e_engine.sv
// Streams the digits of e in base RADIX using the mixed-radix spigot
// e = 2 + 1/2(1 + 1/3(1 + 1/4(...))). Remainders a[2..TERMS] start at 1;
// each digit sweeps i = TERMS..2 computing x = a[i]*RADIX + carry,
// a[i] = x mod i, carry = x / i, and the final carry is the digit.
// Ports:
//   clk, rst     : clock, async active-high reset
//   start        : begin a run (only honoured in IDLE)
//   busy         : run in progress (after accepted start .. final handshake)
//   done         : one-cycle pulse after the final digit handshake
//   digit_data   : digit value 0..RADIX-1
//   digit_valid  : digit_data/digit_index valid, held until digit_ready
//   digit_ready  : consumer accept
//   digit_index  : 0 = integer digit, 1..NUM_DIGITS = fractional digits
module spigot_e_engine
  import spigot_pkg::*;
#(
  parameter int RADIX      = 10,
  parameter int TERMS      = 32,
  parameter int NUM_DIGITS = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [3:0]                   digit_data,
  output logic                         digit_valid,
  input  logic                         digit_ready,
  output logic [cw(NUM_DIGITS+1)-1:0]  digit_index
);

  localparam int AW = cw(TERMS + 1);
  localparam int XW = cw(TERMS * RADIX);
  localparam int QW = cw(RADIX);
  localparam int IW = cw(NUM_DIGITS + 1);

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic [3:0]    data_q, data_d;
  logic [IW-1:0] index_q, index_d;
  logic [AW-1:0] i_q, i_d;
  logic [QW-1:0] carry_q, carry_d;

  // Remainder file; only entries 2..TERMS are ever used. Sized to the full
  // address space so i_q indexes it without width adaptation.
  logic [AW-1:0] a_q [2**AW];
  logic          a_we;
  logic [AW-1:0] a_wdata;

  logic [XW-1:0] x;
  logic          div_go, div_ready;
  logic [QW-1:0] div_quot;
  logic [AW-1:0] div_rem;

  // a[i] <= i-1 and carry < RADIX keep x below i*RADIX.
  assign x = XW'(a_q[i_q]) * XW'(RADIX) + XW'(carry_q);

  spigot_divu #(.XW(XW), .AW(AW), .QW(QW)) u_divu (
    .clk      (clk),
    .rst      (rst),
    .go       (div_go),
    .dividend (x),
    .divisor  (i_q),
    .quot     (div_quot),
    .rem      (div_rem),
    .ready    (div_ready)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    i_d     = i_q;
    carry_d = carry_q;
    a_we    = 1'b0;
    a_wdata = '0;
    div_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          busy_d  = 1'b1;
          i_d     = AW'(2);
        end
      end
      INIT: begin
        a_we    = 1'b1;
        a_wdata = AW'(1);
        if (i_q == AW'(TERMS)) begin
          state_d = EMIT_INT;
          valid_d = 1'b1;
          data_d  = 4'(INT_DIGIT_E);
          index_d = '0;
        end else begin
          i_d = i_q + AW'(1);
        end
      end
      EMIT_INT, OUT: begin
        // No computation while a digit is stalled at the output.
        if (digit_ready) begin
          valid_d = 1'b0;
          if (state_q == OUT && index_q == IW'(NUM_DIGITS)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
            i_d     = AW'(TERMS);
            carry_d = '0;
          end
        end
      end
      LOAD: begin
        div_go  = 1'b1;
        state_d = DIV;
      end
      DIV: begin
        if (div_ready) state_d = WRITE;
      end
      WRITE: begin
        a_we    = 1'b1;
        a_wdata = div_rem;
        carry_d = div_quot;
        if (i_q == AW'(2)) begin
          state_d = OUT;
          valid_d = 1'b1;
          data_d  = 4'(div_quot);
          index_d = index_q + IW'(1);
        end else begin
          i_d     = i_q - AW'(1);
          state_d = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      i_q     <= '0;
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      i_q     <= i_d;
      carry_q <= carry_d;
    end
  end

  // Contents are don't-care until INIT has written them, so no reset.
  always_ff @(posedge clk) begin
    if (a_we) a_q[i_q] <= a_wdata;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign digit_valid = valid_q;
  assign digit_data  = data_q;
  assign digit_index = index_q;

endmodule

// File: tb/tb_spigot_e_engine.sv
module tb_spigot_e_engine;

  localparam int D_RADIX = 10, D_TERMS = 32, D_ND = 20;
  localparam int H_RADIX = 16, H_TERMS = 32, H_ND = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       d_start = 1'b0, d_ready = 1'b0;
  logic       d_busy, d_done, d_valid;
  logic [3:0] d_data;
  logic [4:0] d_index;

  logic       h_start = 1'b0, h_ready = 1'b0;
  logic       h_busy, h_done, h_valid;
  logic [3:0] h_data;
  logic [3:0] h_index;

  spigot_e_engine #(.RADIX(D_RADIX), .TERMS(D_TERMS), .NUM_DIGITS(D_ND)) dut (
    .clk(clk), .rst(rst), .start(d_start), .busy(d_busy), .done(d_done),
    .digit_data(d_data), .digit_valid(d_valid), .digit_ready(d_ready),
    .digit_index(d_index)
  );

  spigot_e_engine #(.RADIX(H_RADIX), .TERMS(H_TERMS), .NUM_DIGITS(H_ND)) dut_hex (
    .clk(clk), .rst(rst), .start(h_start), .busy(h_busy), .done(h_done),
    .digit_data(h_data), .digit_valid(h_valid), .digit_ready(h_ready),
    .digit_index(h_index)
  );

  int n_chk = 0;
  int n_fail = 0;

  int exp_dec [21] = '{2,7,1,8,2,8,1,8,2,8,4,5,9,0,4,5,2,3,5,3,6};
  int exp_hex [14] = '{2,11,7,14,1,5,1,6,2,8,10,14,13,2};

  // Observation mux so one collector serves both instances.
  logic       sel_hex = 1'b0;
  logic       m_busy, m_done, m_valid;
  logic [3:0] m_data;
  logic [4:0] m_idx;
  always_comb begin
    m_busy  = sel_hex ? h_busy  : d_busy;
    m_done  = sel_hex ? h_done  : d_done;
    m_valid = sel_hex ? h_valid : d_valid;
    m_data  = sel_hex ? h_data  : d_data;
    m_idx   = sel_hex ? {1'b0, h_index} : d_index;
  end

  int cap_data[$];
  int cap_idx[$];
  int cap_cyc[$];
  int done_cnt, done_cyc, stall_err, dec_done_cyc;
  logic busy_at_done, busy_first;

  // Digits e are only exact when TERMS! > RADIX^(NUM_DIGITS+1).
  initial begin
    real f, pd, ph;
    f = 1.0; pd = 1.0; ph = 1.0;
    for (int k = 2; k <= D_TERMS; k++) f = f * k;
    for (int k = 0; k <= D_ND; k++) pd = pd * D_RADIX;
    for (int k = 0; k <= H_ND; k++) ph = ph * H_RADIX;
    if (!(f > pd) || !(f > ph)) begin
      $display("FAIL accuracy_precondition: TERMS! too small for requested digits");
      $fatal(1, "parameter precondition");
    end
  end

  task automatic start_run(input bit hex);
    sel_hex = hex;
    @(negedge clk);
    if (hex) h_start = 1'b1; else d_start = 1'b1;
  endtask

  // Runs the selected engine cycle by cycle, recording every handshake.
  task automatic collect(input bit hex, input int duty, input int start_at,
                         input int stop_at, input int max_cyc, output bit timed_out);
    bit prev_stall = 0, start_sent = 0, fin = 0, rdy;
    logic [3:0] pd = '0;
    logic [4:0] pi = '0;
    cap_data.delete(); cap_idx.delete(); cap_cyc.delete();
    done_cnt = 0; done_cyc = -1; stall_err = 0;
    busy_at_done = 1'bx; busy_first = 1'bx;
    for (int c = 0; c < max_cyc && !fin; c++) begin
      @(negedge clk);
      if (m_done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; busy_at_done = m_busy; end
      end
      if (prev_stall && (m_valid !== 1'b1 || m_data !== pd || m_idx !== pi)) stall_err++;
      if (start_at >= 0 && cap_data.size() == start_at && !start_sent) begin
        start_sent = 1;
        if (hex) h_start = 1'b1; else d_start = 1'b1;
      end else begin
        if (hex) h_start = 1'b0; else d_start = 1'b0;
      end
      rdy = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      if (hex) h_ready = rdy; else d_ready = rdy;
      if (m_valid && rdy) begin
        if (cap_data.size() == 0) busy_first = m_busy;
        cap_data.push_back(int'(m_data));
        cap_idx.push_back(int'(m_idx));
        cap_cyc.push_back(c);
        if (stop_at >= 0 && cap_data.size() == stop_at) fin = 1;
      end
      prev_stall = m_valid && !rdy;
      pd = m_data; pi = m_idx;
      if (done_cyc >= 0 && c >= done_cyc + 2) fin = 1;
    end
    timed_out = !fin;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (d_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", d_busy); end
    n_chk++; if (d_done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", d_done); end
    n_chk++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", d_valid); end
    n_chk++; if (d_data !== 4'd0)  begin n_fail++; $display("FAIL reset_data: got %0d expected 0", d_data); end
    n_chk++; if (d_index !== 5'd0) begin n_fail++; $display("FAIL reset_index: got %0d expected 0", d_index); end
    n_chk++; if (h_busy !== 1'b0 || h_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hex: got busy %b valid %b expected 0 0", h_busy, h_valid); end
    rst = 1'b0;
  endtask

  task automatic test_decimal();
    bit to;
    start_run(0);
    collect(0, 100, -1, -1, 8000, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL dec_timeout: got timeout expected done"); end
    n_chk++; if (cap_data.size() != 21) begin n_fail++; $display("FAIL dec_count: got %0d expected 21", cap_data.size()); end
    for (int k = 0; k < 21 && k < cap_data.size(); k++) begin
      n_chk++;
      if (cap_data[k] != exp_dec[k] || cap_idx[k] != k) begin
        n_fail++; $display("FAIL dec_digit[%0d]: got %0d@%0d expected %0d@%0d", k, cap_data[k], cap_idx[k], exp_dec[k], k);
      end
    end
    n_chk++; if (busy_first !== 1'b1) begin n_fail++; $display("FAIL dec_busy_run: got %b expected 1", busy_first); end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL dec_done_pulses: got %0d expected 1", done_cnt); end
    n_chk++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL dec_busy_at_done: got %b expected 0", busy_at_done); end
    if (cap_cyc.size() > 0) begin
      n_chk++;
      if (done_cyc != cap_cyc[cap_cyc.size()-1] + 1) begin
        n_fail++; $display("FAIL dec_done_timing: got cycle %0d expected %0d", done_cyc, cap_cyc[cap_cyc.size()-1] + 1);
      end
    end
    for (int k = 2; k < cap_cyc.size(); k++) begin
      n_chk++;
      if (cap_cyc[k] - cap_cyc[k-1] != 31*6 + 1) begin
        n_fail++; $display("FAIL dec_gap[%0d]: got %0d expected 187", k, cap_cyc[k] - cap_cyc[k-1]);
      end
    end
    n_chk++; if (d_busy !== 1'b0) begin n_fail++; $display("FAIL dec_busy_after: got %b expected 0", d_busy); end
    dec_done_cyc = done_cyc;
  endtask

  task automatic test_hex();
    bit to;
    start_run(1);
    collect(1, 100, -1, -1, 6000, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL hex_timeout: got timeout expected done"); end
    n_chk++; if (cap_data.size() != 14) begin n_fail++; $display("FAIL hex_count: got %0d expected 14", cap_data.size()); end
    for (int k = 0; k < 14 && k < cap_data.size(); k++) begin
      n_chk++;
      if (cap_data[k] != exp_hex[k] || cap_idx[k] != k) begin
        n_fail++; $display("FAIL hex_digit[%0d]: got %0h@%0d expected %0h@%0d", k, cap_data[k], cap_idx[k], exp_hex[k], k);
      end
    end
    n_chk++; if (done_cnt != 1 || h_busy !== 1'b0) begin n_fail++; $display("FAIL hex_done: got pulses %0d busy %b expected 1 0", done_cnt, h_busy); end
    sel_hex = 1'b0;
  endtask

  task automatic test_backpressure();
    bit to;
    start_run(0);
    collect(0, 30, -1, -1, 12000, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL bp_timeout: got timeout expected done"); end
    n_chk++; if (cap_data.size() != 21) begin n_fail++; $display("FAIL bp_count: got %0d expected 21", cap_data.size()); end
    for (int k = 0; k < 21 && k < cap_data.size(); k++) begin
      n_chk++;
      if (cap_data[k] != exp_dec[k] || cap_idx[k] != k) begin
        n_fail++; $display("FAIL bp_digit[%0d]: got %0d@%0d expected %0d@%0d", k, cap_data[k], cap_idx[k], exp_dec[k], k);
      end
    end
    n_chk++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d unstable stall cycles expected 0", stall_err); end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_start_during_run();
    bit to;
    start_run(0);
    collect(0, 100, 5, -1, 8000, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL sdr_timeout: got timeout expected done"); end
    n_chk++; if (cap_data.size() != 21) begin n_fail++; $display("FAIL sdr_count: got %0d expected 21", cap_data.size()); end
    for (int k = 0; k < 21 && k < cap_data.size(); k++) begin
      n_chk++;
      if (cap_data[k] != exp_dec[k] || cap_idx[k] != k) begin
        n_fail++; $display("FAIL sdr_digit[%0d]: got %0d@%0d expected %0d@%0d", k, cap_data[k], cap_idx[k], exp_dec[k], k);
      end
    end
    n_chk++; if (done_cyc != dec_done_cyc) begin n_fail++; $display("FAIL sdr_done_timing: got cycle %0d expected %0d", done_cyc, dec_done_cyc); end
    n_chk++; if (done_cnt != 1 || d_busy !== 1'b0) begin n_fail++; $display("FAIL sdr_done: got pulses %0d busy %b expected 1 0", done_cnt, d_busy); end
  endtask

  task automatic test_async_reset();
    bit to;
    start_run(0);
    collect(0, 100, -1, 7, 4000, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL ar_reach_digit7: got timeout expected 7 digits"); end
    // Capture of index 6 seen; 8 cycles later the sweep for digit 7 is in DIV.
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++; if (d_busy !== 1'b0)  begin n_fail++; $display("FAIL ar_busy: got %b expected 0", d_busy); end
    n_chk++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b expected 0", d_valid); end
    n_chk++; if (d_data !== 4'd0)  begin n_fail++; $display("FAIL ar_data: got %0d expected 0", d_data); end
    n_chk++; if (d_index !== 5'd0) begin n_fail++; $display("FAIL ar_index: got %0d expected 0", d_index); end
    n_chk++; if (d_done !== 1'b0)  begin n_fail++; $display("FAIL ar_done: got %b expected 0", d_done); end
    @(negedge clk);
    rst = 1'b0;
    start_run(0);
    collect(0, 100, -1, -1, 8000, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL ar_restart_timeout: got timeout expected done"); end
    n_chk++; if (cap_data.size() != 21) begin n_fail++; $display("FAIL ar_count: got %0d expected 21", cap_data.size()); end
    for (int k = 0; k < 21 && k < cap_data.size(); k++) begin
      n_chk++;
      if (cap_data[k] != exp_dec[k] || cap_idx[k] != k) begin
        n_fail++; $display("FAIL ar_digit[%0d]: got %0d@%0d expected %0d@%0d", k, cap_data[k], cap_idx[k], exp_dec[k], k);
      end
    end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL ar_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_hex();
    test_backpressure();
    test_start_during_run();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
